mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Load/store execution stage directly downstream of the memory-control decoder.
- Consumes the decoded mem_ctrl word, the effective address and the store data.
- Drives one word-wide single-outstanding bus transaction, then returns an aligned, sign- or zero-extended load result to the core.
- Sits between execute and writeback; the core stalls on ready/done.

Parameters:
- XLEN, 32, data/address width (fixed 32; byte lanes = 4).
- TIMEOUT_CYCLES, 255, max cycles waiting for bus_ack before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request strobe; accepted only when ready=1.
- ready  out  1  unit idle, can accept start.
- mem_ctrl  in  32  decoded control word, one of the MEM_CTRL_* constants in types.sv, or 0 for no access.
- load_unsigned  in  1  zero-extend the load result (funct3 bit 2).
- addr  in  32  effective byte address.
- wdata  in  32  store data, right-justified.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result; valid when done=1, held until next accepted start.
- misaligned  out  1  qualifies done: access aborted, alignment error.
- timeout  out  1  qualifies done: access aborted, no bus_ack.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address, {addr[31:2],2'b00}.
- bus_wstrb  out  4  byte-lane write enables (0 for reads).
- bus_wdata  out  32  lane-shifted store data.
- bus_ack  in  1  bus completion; bus_rdata valid same cycle.
- bus_rdata  in  32  read word.

Behaviour:
- Reset values: ready=1, done=0, rdata=0, misaligned=0, timeout=0, bus_req=0, bus_we=0, bus_addr=0, bus_wstrb=0, bus_wdata=0, timeout counter=0. State=IDLE.
- FSM states: IDLE, BUS, RESP.
  - IDLE: ready=1. On start, capture mem_ctrl, load_unsigned, addr and wdata.
    - mem_ctrl=0 or unrecognised -> RESP, no bus access, rdata=0.
    - misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> RESP with misaligned=1, no bus access.
    - otherwise -> BUS.
  - BUS: bus_req=1. bus_we/addr/wstrb/wdata are stable for the whole request.
    - On bus_ack: reads latch the extracted rdata; go to RESP.
    - Counter increments each BUS cycle without ack. When it reaches TIMEOUT_CYCLES, drop bus_req and go to RESP with timeout=1.
    - If ack and the limit coincide, ack wins and timeout=0.
  - RESP: done=1 for exactly one cycle, misaligned/timeout valid; next state IDLE.
- bus_req goes low the cycle after ack. ready=0 in BUS and RESP.
- start while ready=0 is ignored; no queueing.
- Store lanes, with o=addr[1:0]:
  - byte: wstrb = 4'b0001<<o; wdata = {4{wdata[7:0]}}.
  - half: wstrb = 4'b0011<<o; wdata = {2{wdata[15:0]}}.
  - word: wstrb = 4'b1111; wdata unchanged.
- Load extraction:
  - byte = bus_rdata[8*o+:8]; half = bus_rdata[16*o[1]+:16].
  - Sign-extend unless load_unsigned=1, then zero-extend. Word ignores load_unsigned.
  - Stores leave rdata=0.
- Latency: start at cycle 0 -> bus_req from cycle 1 -> ack at cycle k (k>=1) -> done at cycle k+1. With zero-wait ack (k=1), start-to-done is 2 cycles. Aborted or no-op accesses give done at cycle 1.
- Reset mid-operation: state returns to IDLE and bus_req drops on that edge. A late bus_ack arriving in IDLE is ignored and produces no done.
- Back-to-back: start is accepted in the cycle after done, since ready=1 again.

Test Plan:
- Reset, then mem_ctrl=MEM_CTRL_READ_BYTE, load_unsigned=0, addr=0x1003, bus_rdata=0x80FF_FF00, ack on first req cycle -> bus_addr=0x1000, bus_wstrb=0, done at cycle 2, rdata=0xFFFF_FF80.
- Same access with load_unsigned=1 -> rdata=0x0000_0080. READ_HALF at addr=0x1002, bus_rdata=0x8001_1234 -> rdata=0xFFFF_8001.
- MEM_CTRL_STORE_HALF, addr=0x2002, wdata=0xDEAD_BEEF, ack after 3 wait cycles -> bus_we=1, bus_wstrb=4'b1100, bus_wdata=0xBEEF_BEEF, signals held 4 cycles, then done.
- MEM_CTRL_READ_WORD at addr=0x3001 -> no bus_req ever; done=1 with misaligned=1 at cycle 1. mem_ctrl=0 -> done at cycle 1, no flags, rdata=0.
- TIMEOUT_CYCLES=4, bus_ack held 0 -> bus_req high 4 cycles, then done with timeout=1. Ack on the 4th cycle -> done with timeout=0.
- rst_n low during BUS -> bus_req=0 next edge, ready=1. Subsequent stray bus_ack -> no done; start pulsed while busy -> ignored.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store execution stage: one single-outstanding word bus access per start,
// with byte-lane steering for stores and aligned sign/zero extension for loads.
module mem_access_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            ready,
  input  logic [XLEN-1:0] mem_ctrl,
  input  logic            load_unsigned,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            misaligned,
  output logic            timeout,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_wstrb,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);

  // Decoded control words: bit0 = access, bit1 = write, bits[3:2] = size.
  localparam logic [31:0] MEM_CTRL_READ_BYTE  = 32'h0000_0001;
  localparam logic [31:0] MEM_CTRL_READ_HALF  = 32'h0000_0005;
  localparam logic [31:0] MEM_CTRL_READ_WORD  = 32'h0000_0009;
  localparam logic [31:0] MEM_CTRL_STORE_BYTE = 32'h0000_0003;
  localparam logic [31:0] MEM_CTRL_STORE_HALF = 32'h0000_0007;
  localparam logic [31:0] MEM_CTRL_STORE_WORD = 32'h0000_000B;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT_M1 =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_size;
  logic [1:0]       r_off;
  logic             r_uns;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [3:0]       r_wstrb;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_mis;
  logic             r_to;

  logic             w_valid;
  logic             w_we;
  logic [1:0]       w_size;
  logic             w_misal;
  logic [3:0]       w_wstrb;
  logic [31:0]      w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load;
  logic             w_limit;

  always_comb begin
    w_valid = 1'b1;
    w_we    = 1'b0;
    w_size  = SZ_WORD;
    case (mem_ctrl)
      MEM_CTRL_READ_BYTE:  w_size = SZ_BYTE;
      MEM_CTRL_READ_HALF:  w_size = SZ_HALF;
      MEM_CTRL_READ_WORD:  w_size = SZ_WORD;
      MEM_CTRL_STORE_BYTE: begin w_size = SZ_BYTE; w_we = 1'b1; end
      MEM_CTRL_STORE_HALF: begin w_size = SZ_HALF; w_we = 1'b1; end
      MEM_CTRL_STORE_WORD: begin w_size = SZ_WORD; w_we = 1'b1; end
      default:             w_valid = 1'b0;
    endcase
    w_misal = ((w_size == SZ_HALF) && addr[0]) ||
              ((w_size == SZ_WORD) && (addr[1:0] != 2'b00));
  end

  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = wdata;
    case (w_size)
      SZ_BYTE: begin
        w_wstrb = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        w_wstrb = 4'b0011 << addr[1:0];
        w_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    if (!w_we) w_wstrb = 4'b0000;
  end

  always_comb begin
    w_byte = bus_rdata[{r_off, 3'b000} +: 8];
    w_half = bus_rdata[{r_off[1], 4'b0000} +: 16];
    case (r_size)
      SZ_BYTE: w_load = {{24{w_byte[7] & ~r_uns}}, w_byte};
      SZ_HALF: w_load = {{16{w_half[15] & ~r_uns}}, w_half};
      default: w_load = bus_rdata;
    endcase
  end

  // A limit of zero never fires, so the wait for bus_ack is unbounded.
  assign w_limit = (TIMEOUT_CYCLES != 0) && (r_cnt == LIMIT_M1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = (!w_valid || w_misal) ? S_RESP : S_BUS;
      S_BUS:  if (bus_ack || w_limit) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_size  <= SZ_WORD;
      r_off   <= 2'b00;
      r_uns   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_mis   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (start) begin
            r_rdata <= '0;
            r_mis   <= w_valid & w_misal;
            r_to    <= 1'b0;
            r_size  <= w_size;
            r_off   <= addr[1:0];
            r_uns   <= load_unsigned;
            if (w_valid && !w_misal) begin
              r_we    <= w_we;
              r_addr  <= {addr[31:2], 2'b00};
              r_wstrb <= w_wstrb;
              r_wdata <= w_wdata;
            end
          end
        end
        S_BUS: begin
          // An ack on the limit cycle takes priority over the timeout.
          if (bus_ack) begin
            if (!r_we) r_rdata <= w_load;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_limit) r_to <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready      = (r_state == S_IDLE);
  assign done       = (r_state == S_RESP);
  assign bus_req    = (r_state == S_BUS);
  assign bus_we     = r_we;
  assign bus_addr   = r_addr;
  assign bus_wstrb  = r_wstrb;
  assign bus_wdata  = r_wdata;
  assign rdata      = r_rdata;
  assign misaligned = r_mis;
  assign timeout    = r_to;

endmodule
